// File: rtl/ascon_params.sv
// Shared Ascon masking parameters; MASK_W is the random_masks width consumed by shareCreator.
package ascon_params;

  localparam int unsigned d        = 2;
  localparam int unsigned COL_SIZE = 5;
  localparam int unsigned PAR      = 1;

  localparam int unsigned MASK_W = d * COL_SIZE * PAR;

  typedef logic [MASK_W-1:0] mask_t;

endpackage

// File: rtl/mask_fifo.sv
// Synchronous FIFO for mask words: zeroises each entry as it is popped, with a synchronous clear.
module mask_fifo #(
  parameter  int unsigned Width = 10,
  parameter  int unsigned Depth = 2,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned LvlW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [LvlW-1:0]  cnt_q, cnt_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full_o  = (cnt_q == LvlW'(Depth));
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty && !clear_i;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_d[i] = '0;
      end
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      // Pop and push never share an entry: a push needs a free slot, a pop a filled one.
      if (do_pop) begin
        mem_d[rd_q] = '0;
        rd_d        = rd_q + PtrW'(1);
      end
      if (do_push) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = wr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + LvlW'(1);
        2'b01:   cnt_d = cnt_q - LvlW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = empty ? '0 : mem_q[rd_q];
  assign valid_o = !empty;
  assign level_o = cnt_q;

endmodule

// File: rtl/mask_supplier.sv
// Packs RNG_W-bit entropy chunks into MASK_W-bit mask words and hands them out once each via a FIFO.
module mask_supplier
  import ascon_params::*;
#(
  parameter  int unsigned RNG_W  = 8,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned CHUNKS = (MASK_W + RNG_W - 1) / RNG_W,
  localparam int unsigned IdxW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
  localparam int unsigned LvlW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [RNG_W-1:0]  rnd_in,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic [MASK_W-1:0] mask_out,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [LvlW-1:0]   level
);

  logic [IdxW-1:0] chunk_idx_q, chunk_idx_d;
  mask_t           asm_q, asm_d;
  mask_t           filled;
  logic            fifo_full;
  logic            accept;
  logic            last;
  logic            push;

  assign rnd_ready = !rst && !flush && !fifo_full;
  assign accept    = rnd_valid && rnd_ready;
  assign last      = (chunk_idx_q == IdxW'(CHUNKS - 1));

  // Assembly register with the incoming chunk overlaid; bits past MASK_W simply have no slot.
  for (genvar g = 0; g < int'(MASK_W); g++) begin : g_bits
    localparam int unsigned Chunk = g / RNG_W;
    assign filled[g] = (chunk_idx_q == IdxW'(Chunk)) ? rnd_in[g % RNG_W] : asm_q[g];
  end

  always_comb begin
    chunk_idx_d = chunk_idx_q;
    asm_d       = asm_q;
    push        = 1'b0;
    if (flush) begin
      chunk_idx_d = '0;
      asm_d       = '0;
    end else if (accept) begin
      push        = last;
      asm_d       = last ? '0 : filled;
      chunk_idx_d = last ? '0 : chunk_idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_idx_q <= '0;
      asm_q       <= '0;
    end else begin
      chunk_idx_q <= chunk_idx_d;
      asm_q       <= asm_d;
    end
  end

  mask_fifo #(
    .Width(MASK_W),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (flush),
    .push_i     (push),
    .push_data_i(filled),
    .pop_i      (mask_ready),
    .head_o     (mask_out),
    .valid_o    (mask_valid),
    .full_o     (fifo_full),
    .level_o    (level)
  );

endmodule

// File: tb/tb_mask_supplier.sv
// Directed bench for mask_supplier with MASK_W=10, RNG_W=8, DEPTH=2.
module tb_mask_supplier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] rnd_in = '0;
  logic       rnd_valid = 1'b0;
  logic       rnd_ready;
  logic [9:0] mask_out;
  logic       mask_valid;
  logic       mask_ready = 1'b0;
  logic [1:0] level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mask_supplier #(
    .RNG_W(8),
    .DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .mask_out  (mask_out),
    .mask_valid(mask_valid),
    .mask_ready(mask_ready),
    .level     (level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [7:0] v);
    rnd_in    = v;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
  endtask

  task automatic pop_one();
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
  endtask

  task automatic test_reset();
    rnd_valid = 1'b1;
    #2;
    total++; if (rnd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", rnd_ready); end
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", mask_valid); end
    total++; if (mask_out !== 10'h000) begin bad++; $display("FAIL rst_out got %h want 000", mask_out); end
    total++; if (level !== 2'd0) begin bad++; $display("FAIL rst_level got %0d want 0", level); end
    rnd_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total++; if (rnd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got %b want 1", rnd_ready); end
  endtask

  task automatic test_basic();
    send_chunk(8'hA5);
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %b want 0", mask_valid); end
    send_chunk(8'h03);
    total++; if (mask_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1", mask_valid); end
    total++; if (mask_out !== 10'h3A5) begin bad++; $display("FAIL basic_out got %h want 3a5", mask_out); end
    total++; if (level !== 2'd1) begin bad++; $display("FAIL basic_level got %0d want 1", level); end
    tick();
    total++; if (mask_out !== 10'h3A5) begin bad++; $display("FAIL basic_hold got %h want 3a5", mask_out); end
    pop_one();
    total++; if (level !== 2'd0) begin bad++; $display("FAIL basic_pop_level got %0d want 0", level); end
  endtask

  task automatic test_truncation();
    send_chunk(8'hFF);
    send_chunk(8'hFE);
    total++; if (mask_out !== 10'h2FF) begin bad++; $display("FAIL trunc_out got %h want 2ff", mask_out); end
    pop_one();
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL trunc_pop_valid got %b want 0", mask_valid); end
    total++; if (level !== 2'd0) begin bad++; $display("FAIL trunc_pop_level got %0d want 0", level); end
    total++; if (mask_out !== 10'h000) begin bad++; $display("FAIL trunc_pop_out got %h want 000", mask_out); end
    total++; if (dut.u_fifo.mem_q[0] !== 10'h000) begin bad++; $display("FAIL zeroise_e0 got %h want 000", dut.u_fifo.mem_q[0]); end
    total++; if (dut.u_fifo.mem_q[1] !== 10'h000) begin bad++; $display("FAIL zeroise_e1 got %h want 000", dut.u_fifo.mem_q[1]); end
  endtask

  task automatic test_full();
    send_chunk(8'h01);
    send_chunk(8'h02);
    send_chunk(8'h03);
    send_chunk(8'h00);
    total++; if (level !== 2'd2) begin bad++; $display("FAIL full_level got %0d want 2", level); end
    total++; if (rnd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", rnd_ready); end
    rnd_in = 8'h55;
    rnd_valid = 1'b1;
    tick();
    tick();
    total++; if (level !== 2'd2) begin bad++; $display("FAIL full_held_level got %0d want 2", level); end
    total++; if (mask_out !== 10'h201) begin bad++; $display("FAIL full_head got %h want 201", mask_out); end
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
    total++; if (rnd_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got %b want 1", rnd_ready); end
    total++; if (level !== 2'd1) begin bad++; $display("FAIL full_pop_level got %0d want 1", level); end
    total++; if (mask_out !== 10'h003) begin bad++; $display("FAIL full_second got %h want 003", mask_out); end
    tick();
    rnd_valid = 1'b0;
    send_chunk(8'h01);
    total++; if (level !== 2'd2) begin bad++; $display("FAIL full_refill_level got %0d want 2", level); end
    total++; if (mask_out !== 10'h003) begin bad++; $display("FAIL full_refill_head got %h want 003", mask_out); end
    pop_one();
    total++; if (mask_out !== 10'h155) begin bad++; $display("FAIL full_third got %h want 155", mask_out); end
    pop_one();
    total++; if (level !== 2'd0) begin bad++; $display("FAIL full_drain_level got %0d want 0", level); end
  endtask

  task automatic test_back_to_back();
    send_chunk(8'h10);
    send_chunk(8'h01);
    total++; if (mask_out !== 10'h110) begin bad++; $display("FAIL b2b_first got %h want 110", mask_out); end
    send_chunk(8'h22);
    rnd_in     = 8'h03;
    rnd_valid  = 1'b1;
    mask_ready = 1'b1;
    tick();
    rnd_valid  = 1'b0;
    mask_ready = 1'b0;
    total++; if (level !== 2'd1) begin bad++; $display("FAIL b2b_level got %0d want 1", level); end
    total++; if (mask_out !== 10'h322) begin bad++; $display("FAIL b2b_out got %h want 322", mask_out); end
    pop_one();
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", mask_valid); end
  endtask

  task automatic test_flush();
    send_chunk(8'h12);
    send_chunk(8'h02);
    send_chunk(8'h5A);
    total++; if (level !== 2'd1) begin bad++; $display("FAIL flush_pre_level got %0d want 1", level); end
    flush     = 1'b1;
    rnd_in    = 8'h77;
    rnd_valid = 1'b1;
    #1;
    total++; if (rnd_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got %b want 0", rnd_ready); end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    rnd_valid = 1'b0;
    total++; if (level !== 2'd0) begin bad++; $display("FAIL flush_level got %0d want 0", level); end
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", mask_valid); end
    total++; if (dut.u_fifo.mem_q[0] !== 10'h000 || dut.u_fifo.mem_q[1] !== 10'h000) begin
      bad++; $display("FAIL flush_storage got %h/%h want 000/000", dut.u_fifo.mem_q[0], dut.u_fifo.mem_q[1]);
    end
    send_chunk(8'h11);
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL flush_partial got %b want 0", mask_valid); end
    send_chunk(8'h02);
    total++; if (mask_out !== 10'h211) begin bad++; $display("FAIL flush_out got %h want 211", mask_out); end
    pop_one();
  endtask

  task automatic test_reset_mid_word();
    send_chunk(8'h33);
    #3;
    rst = 1'b1;
    #1;
    total++; if (rnd_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got %b want 0", rnd_ready); end
    total++; if (mask_valid !== 1'b0 || mask_out !== 10'h000 || level !== 2'd0) begin
      bad++; $display("FAIL arst_out got v=%b o=%h l=%0d want v=0 o=000 l=0", mask_valid, mask_out, level);
    end
    tick();
    rst = 1'b0;
    tick();
    send_chunk(8'h44);
    total++; if (mask_valid !== 1'b0) begin bad++; $display("FAIL arst_stale got %b want 0", mask_valid); end
    send_chunk(8'h01);
    total++; if (mask_out !== 10'h144) begin bad++; $display("FAIL arst_word got %h want 144", mask_out); end
    total++; if (level !== 2'd1) begin bad++; $display("FAIL arst_level got %0d want 1", level); end
    pop_one();
    total++; if (level !== 2'd0) begin bad++; $display("FAIL arst_drain got %0d want 0", level); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
